// File: rtl/a0_monitor.sv
// a0_monitor: peripheral-side partner of the register file's I/O convention.
//   - Captures every change of the register file's a0 output into a small FIFO that a
//     display or host drains over a valid/ready stream.
//   - Debounces a raw push-button into a clean trigger level for the register file.
// Ports:
//   i_clk        clock shared with the CPU core
//   i_rst_n      synchronous active-low reset
//   i_a0         live a0 value from the register file
//   i_btn        raw asynchronous push-button
//   o_trigger    debounced button level
//   o_out_data   FIFO head (oldest captured value), don't-care while o_out_valid=0
//   o_out_valid  FIFO not empty
//   i_out_ready  consumer accepts the head this cycle
//   o_count      FIFO occupancy, 0..DEPTH
//   o_overflow   sticky: at least one change was dropped because the FIFO was full
module a0_monitor #(
    parameter int unsigned D_WIDTH   = 32,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned DB_CYCLES = 1000
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [D_WIDTH-1:0]     i_a0,
    input  logic                   i_btn,
    output logic                   o_trigger,
    output logic [D_WIDTH-1:0]     o_out_data,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_overflow
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned DBW = $clog2(DB_CYCLES + 1);

    localparam logic [CW-1:0]  FULL_C = CW'(DEPTH);
    localparam logic [DBW-1:0] DB_C   = DBW'(DB_CYCLES);

    // FIFO state
    logic [D_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;
    logic               r_overflow;

    // Change detect
    logic [D_WIDTH-1:0] r_a0_last;

    // Debounce
    logic               r_sync1;
    logic               r_sync2;
    logic               r_trigger;
    logic [DBW-1:0]     r_db_cnt;

    logic               w_change;
    logic               w_pop;
    logic               w_push;
    logic               w_btn_diff;

    assign w_change   = (i_a0 != r_a0_last);
    assign w_pop      = (r_count != '0) && i_out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push     = w_change && ((r_count != FULL_C) || w_pop);
    assign w_btn_diff = (r_sync2 != r_trigger);

    // Storage is not reset: contents are only visible through the valid pointer range.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_a0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_a0_last  <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_a0_last <= i_a0;
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_change && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // The counter tallies consecutive cycles where the synchronized button disagrees
    // with trigger; trigger follows on the edge after DB_CYCLES such cycles have been
    // counted. With the two sync stages a stable change lands on trigger DB_CYCLES+2
    // edges after the button is first sampled at its new level.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_trigger <= 1'b0;
            r_db_cnt  <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (w_btn_diff) begin
                if (r_db_cnt == DB_C) begin
                    r_trigger <= r_sync2;
                    r_db_cnt  <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DBW'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    assign o_out_data  = r_mem[r_rptr];
    assign o_out_valid = (r_count != '0);
    assign o_count     = r_count;
    assign o_overflow  = r_overflow;
    assign o_trigger   = r_trigger;

endmodule

// File: tb/tb_a0_monitor.sv
// Self-checking bench for a0_monitor (DEPTH=4, DB_CYCLES=4) with a queue-based
// reference model and a history-window debounce model.
module tb_a0_monitor;

    localparam int unsigned DW = 32;
    localparam int unsigned DP = 4;
    localparam int unsigned DB = 4;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] a0;
    logic          btn;
    logic          ready;
    logic          trigger;
    logic [DW-1:0] out_data;
    logic          valid;
    logic [2:0]    count;
    logic          ovf;

    a0_monitor #(
        .D_WIDTH   (DW),
        .DEPTH     (DP),
        .DB_CYCLES (DB)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_a0        (a0),
        .i_btn       (btn),
        .o_trigger   (trigger),
        .o_out_data  (out_data),
        .o_out_valid (valid),
        .i_out_ready (ready),
        .o_count     (count),
        .o_overflow  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_last;
    bit            m_ovf;
    bit            m_trig;
    bit            hist[$];   // value entering the first sync stage at each edge

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Applies the documented rules to the inputs sampled at one clock edge.
    task automatic model_edge();
        int  n;
        bit  all_diff;
        bit  pop;
        if (!rst_n) begin
            mq.delete();
            m_last = '0;
            m_ovf  = 1'b0;
            m_trig = 1'b0;
            hist.delete();
            hist.push_back(1'b0);
            hist.push_back(1'b0);
        end else begin
            // Synchronized level seen before this edge is hist[n-2]; trigger flips when
            // the last DB+1 of those all disagree with it.
            n = hist.size();
            all_diff = (n - 2 - int'(DB)) >= 0;
            if (all_diff) begin
                for (int i = n - 2 - int'(DB); i <= n - 2; i++) begin
                    if (hist[i] == m_trig) all_diff = 1'b0;
                end
            end
            if (all_diff) m_trig = !m_trig;
            hist.push_back(btn);
            if (hist.size() > 32) void'(hist.pop_front());

            pop = (mq.size() != 0) && ready;
            if (pop) void'(mq.pop_front());
            if (a0 != m_last) begin
                if (mq.size() < DP) mq.push_back(a0);
                else m_ovf = 1'b1;
            end
            m_last = a0;
        end
    endtask

    task automatic check_outputs();
        check_eq("count", 64'(count), 64'(mq.size()));
        check_eq("valid", 64'(valid), 64'(mq.size() != 0));
        if (mq.size() != 0) check_eq("data", 64'(out_data), 64'(mq[0]));
        check_eq("overflow", 64'(ovf), 64'(m_ovf));
        check_eq("trigger", 64'(trigger), 64'(m_trig));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) step();
        rst_n = 1'b1;
    endtask

    // Returns the 1-based step index at which trigger first equals lvl, 0 on timeout.
    task automatic wait_trigger(input bit lvl, output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (trigger == lvl && lat == 0) lat = i;
        end
    endtask

    int lat;

    initial begin
        rst_n = 1'b0;
        a0    = 32'd5;
        btn   = 1'b1;
        ready = 1'b0;

        // 1. Reset with a0=5, btn=1
        do_reset(3);
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_valid", 64'(valid), 64'd0);
        check_eq("rst_trig", 64'(trigger), 64'd0);
        check_eq("rst_ovf", 64'(ovf), 64'd0);
        btn = 1'b0;
        step();
        check_eq("post_rst_count", 64'(count), 64'd1);
        check_eq("post_rst_data", 64'(out_data), 64'd5);
        step();
        check_eq("post_rst_count2", 64'(count), 64'd1);

        // 2. Change capture
        a0 = 32'd0;
        do_reset(1);
        begin
            logic [DW-1:0] seq2 [5];
            seq2 = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd3};
            for (int i = 0; i < 5; i++) begin
                a0 = seq2[i];
                step();
            end
        end
        step();
        check_eq("cap_count", 64'(count), 64'd3);
        check_eq("cap_head", 64'(out_data), 64'd1);
        ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check_eq("cap_empty", 64'(valid), 64'd0);
        check_eq("cap_ovf", 64'(ovf), 64'd0);
        ready = 1'b0;

        // 3. Full and overflow
        a0 = 32'd0;
        do_reset(1);
        for (int v = 1; v <= 6; v++) begin
            a0 = DW'(v);
            step();
        end
        check_eq("full_count", 64'(count), 64'd4);
        check_eq("full_ovf", 64'(ovf), 64'd1);
        check_eq("full_head", 64'(out_data), 64'd1);
        ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        ready = 1'b0;
        for (int v = 7; v <= 10; v++) begin
            a0 = DW'(v);
            step();
        end
        check_eq("refill_count", 64'(count), 64'd4);
        ready = 1'b1;
        a0    = 32'd11;
        step();
        ready = 1'b0;
        step();
        check_eq("pushpop_count", 64'(count), 64'd4);
        check_eq("pushpop_head", 64'(out_data), 64'd8);
        ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check_eq("pushpop_last", 64'(out_data), 64'd11);
        step();

        // 4. Wrap-around with a draining consumer
        do_reset(1);
        ready = 1'b1;
        for (int v = 20; v < 30; v++) begin
            a0 = DW'(v);
            step();
            check_eq("wrap_cnt_le1", 64'(count <= 3'd1), 64'd1);
        end
        step();
        check_eq("wrap_empty", 64'(valid), 64'd0);
        ready = 1'b0;

        // 5. Debounce
        btn = 1'b0;
        do_reset(1);
        for (int i = 0; i < 4; i++) step();
        btn = 1'b1;
        for (int i = 0; i < 3; i++) step();
        btn = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check_eq("glitch_trig", 64'(trigger), 64'd0);
        btn = 1'b1;
        wait_trigger(1'b1, lat);
        check_eq("rise_latency", 64'(lat), 64'd7);
        btn = 1'b0;
        wait_trigger(1'b0, lat);
        check_eq("fall_latency", 64'(lat), 64'd7);

        // 6. Reset mid-stream
        a0 = 32'd0;
        do_reset(1);
        for (int v = 1; v <= 5; v++) begin
            a0 = DW'(v);
            step();
        end
        ready = 1'b1;
        step();
        ready = 1'b0;
        check_eq("mid_count3", 64'(count), 64'd3);
        check_eq("mid_ovf_set", 64'(ovf), 64'd1);
        btn = 1'b1;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        step();
        check_eq("mid_rst_count", 64'(count), 64'd0);
        check_eq("mid_rst_valid", 64'(valid), 64'd0);
        check_eq("mid_rst_trig", 64'(trigger), 64'd0);
        check_eq("mid_rst_ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;
        wait_trigger(1'b1, lat);
        check_eq("mid_rise_latency", 64'(lat), 64'd7);

        // 7. Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) != 0) a0 = DW'($urandom_range(0, 3));
            ready = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) btn = !btn;
            if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
